route_loop_sequencer: RTL and testbench
=======================================

// Module: route_loop_sequencer
// PURPOSE
//  Sequences a pattern test through an externally placed chain of SLICE
//  registers whose Q->A routing arcs are under test (Q0 of stage k feeds A0 of stage k+1).
//  Flushes the chain, streams LFSR bits into the first stage and compares the last
//  stage against a delayed copy. Counts mismatches and reports pass/fail.
//  Used in LFCPNX routing fuzz/validation designs to confirm that enumerated arcs
//  carry data.
// PARAMETERS
//  CHAIN_LEN    8        register stages in chain (>=1); also flush/drain length
//  NUM_VECTORS  256      LFSR bits streamed per run (>=1)
//  LFSR_SEED    16'hACE1 nonzero seed of 16-bit Fibonacci LFSR, taps 16,14,13,11
//  CNT_W        16       width of err_count
// PORTS
//  clk        in   1      single clock; chain registers share it
//  rst        in   1      synchronous, active-high reset
//  start      in   1      run request, sampled only in IDLE
//  chain_d    out  1      data into first chain stage (A0)
//  chain_en   out  1      clock enable to all chain stages
//  chain_q    in   1      data from last chain stage (Q0)
//  busy       out  1      high from cycle after start accepted until DONE exits
//  done       out  1      one-cycle pulse in DONE
//  pass       out  1      valid when done=1 and held until next start: err_count==0
//  err_count  out  CNT_W  mismatch count, saturating at 2^CNT_W-1
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE; chain_d=0, chain_en=0, busy=0, done=0,
//    pass=0, err_count=0; LFSR=LFSR_SEED; expected delay line and valid bits cleared.
//    rst overrides start. Mid-run reset aborts immediately without a done pulse.
//  - Chain model: chain_q(t) = chain_d(t-CHAIN_LEN) when chain_en is held high.
//  - FSM: IDLE -> FLUSH -> RUN -> DRAIN -> DONE -> IDLE.
//    IDLE: start=1 -> FLUSH. Clear err_count and pass; reload LFSR_SEED.
//    FLUSH: CHAIN_LEN cycles. chain_en=1, chain_d=0, no comparisons.
//    RUN: NUM_VECTORS cycles. chain_d=LFSR bit0, LFSR steps every cycle.
//      Each driven bit enters the expected delay line (depth CHAIN_LEN) with valid=1.
//    DRAIN: CHAIN_LEN cycles. chain_d=0; delay line is fed valid=0.
//    DONE: 1 cycle. done=1, pass=(err_count==0), chain_en=0.
//  - Compare: on every cycle in RUN/DRAIN where the delay-line tail is valid and
//    chain_q != tail bit, err_count increments (saturating). Exactly NUM_VECTORS
//    compares per run.
//  - busy=1 in FLUSH/RUN/DRAIN/DONE. start while busy is ignored and is not queued.
//  - Latency: start sampled at edge E0 -> done high for the cycle after edge
//    E0 + 2*CHAIN_LEN + NUM_VECTORS.
//  - Phase counters are sized $clog2(max(CHAIN_LEN,NUM_VECTORS)+1). No wrap
//    within a run.
//  - chain_en=0 in IDLE and DONE: chain contents are frozen between runs.
// STRUCTURE
//  - Package route_seq_pkg: state enum {IDLE,FLUSH,RUN,DRAIN,DONE}, LFSR width
//    and tap constant, default seed.
//  - Sub-module lfsr16 (clk, rst, load, seed, step, bit_out).
//  - Top holds FSM, phase counter, expected delay line and saturating error counter.
// TESTING
//  1 Ideal 8-flop chain model, defaults: start pulse -> done at E0+273,
//    pass=1, err_count=0, busy low the cycle after done.
//  2 Invert chain_q on one RUN vector only -> err_count=1, pass=0.
//  3 chain_q tied 0 -> err_count = popcount of first 256 LFSR bits from
//    16'hACE1 (bench reference model); tied 1 -> 256 minus that popcount.
//  4 CNT_W=4, chain_q inverted on every cycle -> err_count saturates at 15 and
//    stays at 15; pass=0.
//  5 rst=1 in RUN cycle 100 -> next cycle IDLE, all outputs at reset values,
//    no done. A later start runs cleanly: pass=1.
//  6 start held high through a run -> one run only; the next start is accepted
//    the first cycle back in IDLE. CHAIN_LEN=1, NUM_VECTORS=1 -> done at E0+4.

Source files
------------

// File: rtl/route_seq_pkg.sv
// Shared types and constants for the routing-loop pattern sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package route_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int LFSR_W = 16;
    // Fibonacci taps 16,14,13,11 map to bits 0,2,3,5 of a right-shifting register
    localparam logic [LFSR_W-1:0] LFSR_FB_MASK = 16'h002D;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_FB_MASK), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; bit_out is the current bit 0.
// Latency: load/step take effect at the next clock edge.
// Backpressure: advances only when step is high; load has priority.
module lfsr16
    import route_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic              bit_out
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/route_loop_sequencer.sv
// Flush / stream / drain a pattern through an external register chain and count mismatches.
// Latency: start at edge E0 -> done in the cycle after edge E0 + 2*CHAIN_LEN + NUM_VECTORS.
// Backpressure: none; start is ignored (not queued) while busy.
module route_loop_sequencer
    import route_seq_pkg::*;
#(
    parameter int                CHAIN_LEN   = 8,
    parameter int                NUM_VECTORS = 256,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = DEFAULT_SEED,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             chain_d,
    output logic             chain_en,
    input  logic             chain_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
);

    localparam int PH_MAX = (CHAIN_LEN > NUM_VECTORS) ? CHAIN_LEN : NUM_VECTORS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_e               state_q, state_d;
    logic [PH_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic                 pass_q, pass_d;
    logic [CHAIN_LEN-1:0] dv_q, dv_d;
    logic [CHAIN_LEN-1:0] db_q, db_d;

    logic lfsr_load;
    logic lfsr_step;
    logic lfsr_bit;
    logic shift;
    logic in_vld;
    logic cmp_en;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .step    (lfsr_step),
        .bit_out (lfsr_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        shift     = 1'b0;
        in_vld    = 1'b0;
        cmp_en    = 1'b0;
        chain_d   = 1'b0;
        chain_en  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        pass      = pass_q;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = FLUSH;
                    cnt_d     = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            FLUSH: begin
                chain_en = 1'b1;
                shift    = 1'b1;
                if (int'(cnt_q) == CHAIN_LEN - 1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            RUN: begin
                chain_en  = 1'b1;
                chain_d   = lfsr_bit;
                lfsr_step = 1'b1;
                shift     = 1'b1;
                in_vld    = 1'b1;
                cmp_en    = 1'b1;
                if (int'(cnt_q) == NUM_VECTORS - 1) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            DRAIN: begin
                chain_en = 1'b1;
                shift    = 1'b1;
                cmp_en   = 1'b1;
                if (int'(cnt_q) == CHAIN_LEN - 1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                pass    = (err_q == '0);
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Expected-data delay line mirrors the external chain depth; only RUN bits are valid.
        dv_d = dv_q;
        db_d = db_q;
        if (shift) begin
            dv_d[0] = in_vld;
            db_d[0] = chain_d;
            for (int i = 1; i < CHAIN_LEN; i++) begin
                dv_d[i] = dv_q[i-1];
                db_d[i] = db_q[i-1];
            end
        end

        if (cmp_en && dv_q[CHAIN_LEN-1] && (chain_q != db_q[CHAIN_LEN-1]) && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            dv_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            dv_q    <= dv_d;
            db_q    <= db_d;
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_route_loop_sequencer.sv
// Bench for route_loop_sequencer: three instances (default, 4-bit counter, 1/1 lengths)
// each closed through a behavioural register-chain model with optional faults.
module tb_route_loop_sequencer;

    localparam int LA  = 8;
    localparam int NA  = 256;
    localparam int LB  = 8;
    localparam int NB  = 256;
    localparam int CWB = 4;
    localparam int LC  = 1;
    localparam int NC  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: defaults ----------------
    logic        a_start = 1'b0;
    logic        a_d, a_en, a_q, a_busy, a_done, a_pass;
    logic [15:0] a_err;

    route_loop_sequencer #(
        .CHAIN_LEN(LA), .NUM_VECTORS(NA), .LFSR_SEED(16'hACE1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .chain_d(a_d), .chain_en(a_en),
        .chain_q(a_q), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err)
    );

    logic [LA-1:0] cha = '0;
    always @(posedge clk) if (a_en) cha <= {cha[LA-2:0], a_d};

    // mode: 0 ideal, 1 invert one vector (a_kf), 2 tied 0, 3 tied 1
    int a_mode = 0;
    int a_kf   = 0;
    int a_e0   = 0;
    bit a_active = 1'b0;

    assign a_q = (a_mode == 2) ? 1'b0 :
                 (a_mode == 3) ? 1'b1 :
                 (cha[LA-1] ^ ((a_mode == 1) && ((cyc - a_e0 - 1) == 2*LA + a_kf)));

    // ---------------- instance B: 4-bit counter, always-inverted chain ----------------
    logic           b_start = 1'b0;
    logic           b_d, b_en, b_q, b_busy, b_done, b_pass;
    logic [CWB-1:0] b_err;

    route_loop_sequencer #(
        .CHAIN_LEN(LB), .NUM_VECTORS(NB), .LFSR_SEED(16'hACE1), .CNT_W(CWB)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .chain_d(b_d), .chain_en(b_en),
        .chain_q(b_q), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err)
    );

    logic [LB-1:0] chb = '0;
    always @(posedge clk) if (b_en) chb <= {chb[LB-2:0], b_d};
    assign b_q = ~chb[LB-1];

    // ---------------- instance C: one stage, one vector ----------------
    logic        c_start = 1'b0;
    logic        c_d, c_en, c_q, c_busy, c_done, c_pass;
    logic [15:0] c_err;

    route_loop_sequencer #(
        .CHAIN_LEN(LC), .NUM_VECTORS(NC), .LFSR_SEED(16'hACE1), .CNT_W(16)
    ) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .chain_d(c_d), .chain_en(c_en),
        .chain_q(c_q), .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err)
    );

    logic chc = 1'b0;
    always @(posedge clk) if (c_en) chc <= c_d;
    assign c_q = chc;

    // ---------------- reference model ----------------
    bit seq [NA];
    int pop = 0;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic bit mism(input int k);
        case (a_mode)
            1:       return (k == a_kf);
            2:       return seq[k];
            3:       return !seq[k];
            default: return 1'b0;
        endcase
    endfunction

    // Cycle index j counts cycles after the start-accepting edge (j=0 is the first busy cycle).
    int m_j, m_cnt;
    int a_done_j = -1, a_done_err = -1, a_done_pass = -1;
    int a_done_cnt = 0;

    always @(negedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

    always @(negedge clk) begin
        if (a_active) begin
            m_j   = cyc - a_e0 - 1;
            m_cnt = 0;
            for (int k = 0; k < NA; k++) begin
                if ((2*LA + k < m_j) && mism(k)) m_cnt++;
            end
            chk("busy",      int'(a_busy), int'(m_j <= 2*LA + NA));
            chk("done",      int'(a_done), int'(m_j == 2*LA + NA));
            chk("chain_en",  int'(a_en),   int'(m_j < 2*LA + NA));
            chk("chain_d",   int'(a_d),    (m_j >= LA && m_j < LA + NA) ? int'(seq[m_j-LA]) : 0);
            chk("err_count", int'(a_err),  m_cnt);
            chk("pass",      int'(a_pass), int'((m_j >= 2*LA + NA) && (m_cnt == 0)));
            if (a_done) begin
                a_done_j    = m_j;
                a_done_err  = int'(a_err);
                a_done_pass = int'(a_pass);
            end
        end
    end

    task automatic run_a(input int mode, input int kf);
        a_mode = mode;
        a_kf   = kf;
        a_done_j = -1;
        @(negedge clk);
        a_start = 1'b1;
        a_e0    = cyc;
        @(posedge clk);
        a_active = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (2*LA + NA + 2) @(posedge clk);
        a_active = 1'b0;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_busy"},     int'(a_busy), 0);
        chk({tag, "_done"},     int'(a_done), 0);
        chk({tag, "_chain_en"}, int'(a_en),   0);
        chk({tag, "_chain_d"},  int'(a_d),    0);
        chk({tag, "_pass"},     int'(a_pass), 0);
        chk({tag, "_err"},      int'(a_err),  0);
    endtask

    logic [15:0] s;
    int          dcnt_before;
    bit          c_done_log [12];
    bit          c_busy_log [12];
    bit          c_pass_log [12];
    int          c_ndone;

    initial begin
        // Reference LFSR pinned against hand-stepped values from ACE1.
        chk("lfsr_step1", int'(ref_step(16'hACE1)), 32'h5670);
        chk("lfsr_step2", int'(ref_step(16'h5670)), 32'hAB38);
        s = 16'hACE1;
        for (int i = 0; i < NA; i++) begin
            seq[i] = s[0];
            pop += int'(s[0]);
            s = ref_step(s);
        end
        chk("seq_first3", int'({seq[0], seq[1], seq[2]}), 3'b100);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_a("reset");
        chk("reset_b_err", int'(b_err), 0);
        rst = 1'b0;

        // 1: ideal chain
        run_a(0, 0);
        chk("t1_done_latency", a_done_j, 272);
        chk("t1_err", a_done_err, 0);
        chk("t1_pass", a_done_pass, 1);

        // 2: single inverted vector
        run_a(1, 37);
        chk("t2_err", a_done_err, 1);
        chk("t2_pass", a_done_pass, 0);

        // 3: tied 0 then tied 1
        run_a(2, 0);
        chk("t3_tied0_err", a_done_err, pop);
        run_a(3, 0);
        chk("t3_tied1_err", a_done_err, NA - pop);
        chk("t3_tied1_pass", a_done_pass, 0);

        // 5: reset in RUN cycle 100 aborts without done
        a_mode = 1;
        a_kf   = 5;
        @(negedge clk);
        a_start = 1'b1;
        a_e0    = cyc;
        @(posedge clk);
        a_active = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (LA + 100) @(posedge clk);
        @(negedge clk);
        a_active = 1'b0;
        chk("t5_err_before_rst", int'(a_err), 1);
        dcnt_before = a_done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_a("t5_after_rst");
        rst = 1'b0;
        repeat (LA + NA + 20) @(posedge clk);
        @(negedge clk);
        chk("t5_no_done", a_done_cnt, dcnt_before);
        chk("t5_still_idle", int'(a_busy), 0);
        run_a(0, 0);
        chk("t5_rerun_pass", a_done_pass, 1);
        chk("t5_rerun_latency", a_done_j, 272);

        // 4: 4-bit counter saturates
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 2*LB + NB + 3; j++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (j == 2*LB + 14) chk("t4_err_pre_sat", int'(b_err), 14);
            if (j == 2*LB + 20) chk("t4_err_sat", int'(b_err), 15);
            if (j == 2*LB + NB) begin
                chk("t4_done", int'(b_done), 1);
                chk("t4_err_done", int'(b_err), 15);
                chk("t4_pass_done", int'(b_pass), 0);
            end
            if (j == 2*LB + NB + 3) begin
                chk("t4_err_held", int'(b_err), 15);
                chk("t4_pass_held", int'(b_pass), 0);
                chk("t4_busy_low", int'(b_busy), 0);
            end
        end

        // 6: start held high on a 1-stage / 1-vector instance
        @(negedge clk);
        c_start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            c_done_log[j] = c_done;
            c_busy_log[j] = c_busy;
            c_pass_log[j] = c_pass;
        end
        c_start = 1'b0;
        c_ndone = 0;
        for (int j = 0; j < 12; j++) c_ndone += int'(c_done_log[j]);
        chk("t6_done_count", c_ndone, 2);
        chk("t6_first_done", int'(c_done_log[3]), 1);
        chk("t6_first_pass", int'(c_pass_log[3]), 1);
        chk("t6_idle_gap", int'(c_busy_log[4]), 0);
        chk("t6_reaccept", int'(c_busy_log[5]), 1);
        chk("t6_second_done", int'(c_done_log[8]), 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6_final_err", int'(c_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
